// File: rtl/led_pkg.sv
// Shared definitions for the LED blink sequencer family: state encodings,
// default timing parameters and the zero-duration clamp.
package led_pkg;

  localparam int LED_CLK_DIV = 25;
  localparam int LED_TIME_W  = 8;
  localparam int LED_NUM_W   = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_ON   = 2'd1;
  localparam state_t ST_OFF  = 2'd2;
  localparam state_t ST_GAP  = 2'd3;

  // A zero duration would never expire cleanly, so it runs as one tick.
  function automatic logic [31:0] dur_clamp(input logic [31:0] d);
    return (d == 32'd0) ? 32'd1 : d;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Prescaler: one-cycle tick every CLK_DIV enabled cycles; holds while i_en
// is low and restarts from zero on i_clr.
module led_tick_gen #(
  parameter int CLK_DIV = 25
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      cnt <= '0;
    end else if (i_en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign o_tick = i_en && !i_clr && (cnt == LAST);

endmodule

// File: rtl/led_blink_sequencer.sv
// Command-driven LED sequencer: N ON/OFF blinks then a GAP, optionally looped.
// Commands are taken only in IDLE; abort returns to IDLE on the next cycle.
module led_blink_sequencer
  import led_pkg::*;
#(
  parameter int CLK_DIV = LED_CLK_DIV,
  parameter int TIME_W  = LED_TIME_W,
  parameter int NUM_W   = LED_NUM_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [NUM_W-1:0]  i_cmd_count,
  input  logic [TIME_W-1:0] i_cmd_on,
  input  logic [TIME_W-1:0] i_cmd_off,
  input  logic [TIME_W-1:0] i_cmd_gap,
  input  logic              i_cmd_repeat,
  input  logic              i_abort,
  output logic              o_led,
  output logic              o_busy,
  output logic              o_done
);

  state_t state;
  state_t state_nxt;

  logic [NUM_W-1:0]  count_q;
  logic [NUM_W-1:0]  remaining;
  logic [TIME_W-1:0] on_q;
  logic [TIME_W-1:0] off_q;
  logic [TIME_W-1:0] gap_q;
  logic              rpt_q;

  logic [TIME_W-1:0] phase;
  logic [TIME_W-1:0] phase_ld;
  logic [TIME_W-1:0] on_src;
  logic [TIME_W-1:0] off_src;
  logic [TIME_W-1:0] gap_src;

  logic tick;
  logic accept;
  logic abort_act;
  logic expire;
  logic clr_presc;

  assign accept    = i_cmd_valid && o_cmd_ready;
  assign abort_act = i_abort && (state != ST_IDLE);
  assign expire    = tick && (phase == '0);
  assign clr_presc = accept || abort_act;

  led_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (i_en),
    .i_clr  (clr_presc),
    .o_tick (tick)
  );

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; abort overrides any expiry in the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = (i_cmd_count != '0) ? ST_ON : ST_GAP;
        end
      end
      ST_ON: begin
        if (expire) begin
          state_nxt = ST_OFF;
        end
      end
      ST_OFF: begin
        if (expire) begin
          state_nxt = (remaining > NUM_W'(1)) ? ST_ON : ST_GAP;
        end
      end
      ST_GAP: begin
        if (expire) begin
          if (rpt_q) begin
            state_nxt = (count_q != '0) ? ST_ON : ST_GAP;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (abort_act) begin
      state_nxt = ST_IDLE;
    end
  end

  // Outputs
  always_comb begin
    o_cmd_ready = (state == ST_IDLE) && !i_rst;
    o_busy      = (state != ST_IDLE) && !i_rst;
    o_done      = 1'b0;
    if (!i_rst && !abort_act && (state == ST_GAP) && expire && !rpt_q) begin
      o_done = 1'b1;
    end
  end

  // On accept the latched fields are not yet valid, so load from the inputs.
  always_comb begin
    on_src  = accept ? i_cmd_on  : on_q;
    off_src = accept ? i_cmd_off : off_q;
    gap_src = accept ? i_cmd_gap : gap_q;
    phase_ld = '0;
    case (state_nxt)
      ST_ON:   phase_ld = TIME_W'(dur_clamp(32'(on_src))  - 32'd1);
      ST_OFF:  phase_ld = TIME_W'(dur_clamp(32'(off_src)) - 32'd1);
      ST_GAP:  phase_ld = TIME_W'(dur_clamp(32'(gap_src)) - 32'd1);
      default: phase_ld = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_q <= '0;
      on_q    <= '0;
      off_q   <= '0;
      gap_q   <= '0;
      rpt_q   <= 1'b0;
    end else if (accept) begin
      count_q <= i_cmd_count;
      on_q    <= i_cmd_on;
      off_q   <= i_cmd_off;
      gap_q   <= i_cmd_gap;
      rpt_q   <= i_cmd_repeat;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || abort_act) begin
      phase <= '0;
    end else if (accept || expire) begin
      phase <= phase_ld;
    end else if (tick) begin
      phase <= phase - 1'b1;
    end
  end

  // Decrement only while more than one blink is left, so it never wraps.
  always_ff @(posedge i_clk) begin
    if (i_rst || abort_act) begin
      remaining <= '0;
    end else if (accept) begin
      remaining <= i_cmd_count;
    end else if (expire) begin
      if ((state == ST_OFF) && (remaining > NUM_W'(1))) begin
        remaining <= remaining - 1'b1;
      end else if ((state == ST_GAP) && rpt_q) begin
        remaining <= count_q;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_led <= 1'b0;
    end else begin
      o_led <= (state_nxt == ST_ON);
    end
  end

endmodule

// File: tb/tb_led_blink_sequencer.sv
// Self-checking bench: per-cycle expected {led,busy,ready,done} queued from a
// duration model and compared at each falling edge.
module tb_led_blink_sequencer;

  localparam int CLK_DIV = 4;
  localparam int TIME_W  = 8;
  localparam int NUM_W   = 4;

  localparam logic [3:0] E_IDLE = 4'b0010;
  localparam logic [3:0] E_ON   = 4'b1100;
  localparam logic [3:0] E_LOW  = 4'b0100;
  localparam logic [3:0] E_DONE = 4'b0101;
  localparam logic [3:0] E_RST  = 4'b0000;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [NUM_W-1:0]  cmd_count = '0;
  logic [TIME_W-1:0] cmd_on = '0;
  logic [TIME_W-1:0] cmd_off = '0;
  logic [TIME_W-1:0] cmd_gap = '0;
  logic              cmd_repeat = 1'b0;
  logic              abort_i = 1'b0;
  logic              led;
  logic              busy;
  logic              done;

  int n_cmp = 0;
  int n_err = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  led_blink_sequencer #(
    .CLK_DIV (CLK_DIV),
    .TIME_W  (TIME_W),
    .NUM_W   (NUM_W)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_en         (en),
    .i_cmd_valid  (cmd_valid),
    .o_cmd_ready  (cmd_ready),
    .i_cmd_count  (cmd_count),
    .i_cmd_on     (cmd_on),
    .i_cmd_off    (cmd_off),
    .i_cmd_gap    (cmd_gap),
    .i_cmd_repeat (cmd_repeat),
    .i_abort      (abort_i),
    .o_led        (led),
    .o_busy       (busy),
    .o_done       (done)
  );

  function automatic int clampd(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  task automatic push_n(input logic [3:0] v, input int n);
    repeat (n) exp_q.push_back(v);
  endtask

  // Non-repeat burst as seen from accept+1; on_extra stretches the first ON.
  task automatic push_burst(input int count, input int on, input int off,
                            input int gap, input int on_extra);
    for (int b = 0; b < count; b++) begin
      push_n(E_ON, clampd(on) * CLK_DIV + ((b == 0) ? on_extra : 0));
      push_n(E_LOW, clampd(off) * CLK_DIV);
    end
    push_n(E_LOW, clampd(gap) * CLK_DIV - 1);
    push_n(E_DONE, 1);
  endtask

  task automatic drive_cmd(input int count, input int on, input int off,
                           input int gap, input logic rpt);
    cmd_valid  = 1'b1;
    cmd_count  = NUM_W'(count);
    cmd_on     = TIME_W'(on);
    cmd_off    = TIME_W'(off);
    cmd_gap    = TIME_W'(gap);
    cmd_repeat = rpt;
  endtask

  task automatic scramble();
    cmd_count  = NUM_W'($urandom);
    cmd_on     = TIME_W'($urandom);
    cmd_off    = TIME_W'($urandom);
    cmd_gap    = TIME_W'($urandom);
    cmd_repeat = 1'($urandom);
  endtask

  task automatic test_reset();
    logic [3:0] e, got;
    push_n(E_RST, 3);
    push_n(E_IDLE, 3);
    for (int c = 0; exp_q.size() > 0; c++) begin
      @(posedge clk); #1;
      rst = (c < 3);
      @(negedge clk);
      got = {led, busy, cmd_ready, done};
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL reset c=%0d led/busy/rdy/done got=%b exp=%b", c, got, e);
      end
    end
  endtask

  task automatic test_basic();
    logic [3:0] e, got;
    push_n(E_IDLE, 1);
    push_burst(2, 3, 2, 5, 0);
    push_n(E_IDLE, 3);
    for (int c = 0; exp_q.size() > 0; c++) begin
      @(posedge clk); #1;
      if (c == 0) drive_cmd(2, 3, 2, 5, 1'b0);
      else begin cmd_valid = 1'b0; scramble(); end
      @(negedge clk);
      got = {led, busy, cmd_ready, done};
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL basic c=%0d led/busy/rdy/done got=%b exp=%b", c, got, e);
      end
    end
  endtask

  task automatic test_zero_fields();
    logic [3:0] e, got;
    push_n(E_IDLE, 1);
    push_burst(0, 0, 0, 0, 0);
    push_n(E_IDLE, 1);
    push_burst(1, 0, 0, 0, 0);
    push_n(E_IDLE, 2);
    for (int c = 0; exp_q.size() > 0; c++) begin
      @(posedge clk); #1;
      if (c == 0) drive_cmd(0, 7, 7, 0, 1'b0);
      else if (c == 5) drive_cmd(1, 0, 0, 0, 1'b0);
      else cmd_valid = 1'b0;
      @(negedge clk);
      got = {led, busy, cmd_ready, done};
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL zero_fields c=%0d led/busy/rdy/done got=%b exp=%b", c, got, e);
      end
    end
  endtask

  task automatic test_repeat_abort();
    logic [3:0] e, got;
    push_n(E_IDLE, 1);
    for (int l = 0; l < 5; l++) begin
      push_n(E_ON, 4);
      push_n(E_LOW, 8);
    end
    push_n(E_ON, 2);
    push_n(E_IDLE, 2);
    push_n(E_LOW, 3);
    push_n(E_DONE, 1);
    push_n(E_IDLE, 2);
    for (int c = 0; exp_q.size() > 0; c++) begin
      @(posedge clk); #1;
      abort_i = (c == 62) || (c == 64);
      if (c == 0) drive_cmd(1, 1, 1, 1, 1'b1);
      else if (c == 64) drive_cmd(0, 0, 0, 0, 1'b0);
      else cmd_valid = 1'b0;
      @(negedge clk);
      got = {led, busy, cmd_ready, done};
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL repeat_abort c=%0d led/busy/rdy/done got=%b exp=%b", c, got, e);
      end
    end
    abort_i = 1'b0;
  endtask

  task automatic test_enable_hold();
    logic [3:0] e, got;
    push_n(E_IDLE, 1);
    push_burst(2, 3, 2, 5, 10);
    push_n(E_IDLE, 2);
    for (int c = 0; exp_q.size() > 0; c++) begin
      @(posedge clk); #1;
      en = !((c >= 3) && (c <= 12));
      if (c == 0) drive_cmd(2, 3, 2, 5, 1'b0);
      else cmd_valid = 1'b0;
      @(negedge clk);
      got = {led, busy, cmd_ready, done};
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL enable_hold c=%0d led/busy/rdy/done got=%b exp=%b", c, got, e);
      end
    end
    en = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [3:0] e, got;
    push_n(E_IDLE, 1);
    push_burst(1, 1, 1, 1, 0);
    push_n(E_IDLE, 1);
    push_burst(1, 2, 1, 1, 0);
    push_n(E_IDLE, 2);
    for (int c = 0; exp_q.size() > 0; c++) begin
      @(posedge clk); #1;
      if (c == 0) drive_cmd(1, 1, 1, 1, 1'b0);
      else if (c < 13) begin cmd_valid = 1'b1; scramble(); end
      else if (c == 13) drive_cmd(1, 2, 1, 1, 1'b0);
      else begin cmd_valid = 1'b0; scramble(); end
      @(negedge clk);
      got = {led, busy, cmd_ready, done};
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL back_to_back c=%0d led/busy/rdy/done got=%b exp=%b", c, got, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] e, got;
    push_n(E_IDLE, 1);
    push_n(E_ON, 12);
    push_n(E_LOW, 8);
    push_n(E_ON, 12);
    push_n(E_LOW, 12);
    push_n(E_RST, 1);
    push_n(E_IDLE, 4);
    for (int c = 0; exp_q.size() > 0; c++) begin
      @(posedge clk); #1;
      rst = (c == 45);
      if (c == 0) drive_cmd(2, 3, 2, 5, 1'b0);
      else cmd_valid = 1'b0;
      @(negedge clk);
      got = {led, busy, cmd_ready, done};
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL reset_mid c=%0d led/busy/rdy/done got=%b exp=%b", c, got, e);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_fields();
    test_repeat_abort();
    test_enable_hold();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/led_blink_sequencer.md
Name: led_blink_sequencer

Overview:
Command-driven LED pattern controller that sequences a single LED through bursts of timed blinks.
- One command gives N blinks of ON/OFF ticks, then a GAP, optionally looped forever.
- Sits between the board-level status logic (boot, error codes) and the LED pin.
- Replaces free-running fixed-divider blinking with countable patterns, e.g. "3 blinks = error 3".

Parameters:
- CLK_DIV, 25, clock cycles per timing tick (CLK_FREQ/1000 on hardware gives 1 ms ticks); must be >= 2.
- TIME_W, 8, width of the on/off/gap duration fields, in ticks.
- NUM_W, 4, width of the blink-count field.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous active-high reset.
- i_en  in  1  timing enable; low freezes the prescaler and phase counters.
- i_cmd_valid  in  1  command offered.
- o_cmd_ready  out  1  sequencer idle and able to accept a command.
- i_cmd_count  in  NUM_W  blinks per burst; 0 means GAP only.
- i_cmd_on  in  TIME_W  ON ticks per blink; 0 is treated as 1.
- i_cmd_off  in  TIME_W  OFF ticks per blink; 0 is treated as 1.
- i_cmd_gap  in  TIME_W  ticks after the burst; 0 is treated as 1.
- i_cmd_repeat  in  1  loop the burst until aborted.
- i_abort  in  1  cancel the active pattern.
- o_led  out  1  LED drive, registered.
- o_busy  out  1  high in any non-IDLE state.
- o_done  out  1  one-cycle pulse on normal completion of a non-repeat command.

Behaviour:
- Reset: state IDLE; o_led=0, o_busy=0, o_done=0, o_cmd_ready=0 during reset cycles and 1 from the first cycle after reset deasserts; prescaler and counters cleared.
- States and transitions:
  - IDLE -> ON on accept when count>0.
  - IDLE -> GAP on accept when count==0.
  - ON -> OFF on expiry.
  - OFF -> ON if remaining>1, else GAP; remaining decrements on each OFF expiry.
  - GAP -> ON, with remaining reloaded, if repeat and count>0.
  - GAP -> GAP reloaded, if repeat and count==0.
  - GAP -> IDLE otherwise, with o_done=1 for exactly that transition cycle.
- Accept: i_cmd_valid & o_cmd_ready at a rising edge. All fields are latched; inputs are don't-care afterwards.
- o_cmd_ready = (state==IDLE) and not in reset. A command held valid while busy is not accepted until ready returns.
- Prescaler:
  - Counts 0..CLK_DIV-1 while i_en=1.
  - tick=1 in the cycle it equals CLK_DIV-1 with i_en=1, then wraps to 0.
  - Cleared to 0 on accept, so the first tick falls CLK_DIV cycles after accept.
- Phase counter:
  - Loaded with duration-1 on entry to ON/OFF/GAP.
  - Decrements on tick. Expiry = tick while the counter is 0.
  - Each phase lasts duration*CLK_DIV enabled cycles.
- o_led: 1 exactly in cycles where state==ON, registered with the state, so o_led rises the cycle after accept. It is 0 in all other states.
- i_en=0: state, counters, prescaler and o_led hold. Accept and abort still operate.
- Abort: in any non-IDLE state, the next cycle is IDLE with o_led=0, o_done=0 and prescaler cleared. i_abort in IDLE is ignored. Abort with i_cmd_valid in IDLE: the command is accepted.
- Reset mid-pattern: immediate return to reset values; no o_done.
- Widths:
  - remaining is NUM_W bits and never underflows, because OFF checks remaining>1 before decrementing.
  - Duration arithmetic is TIME_W bits with no overflow, since loads are duration-1 after the zero->1 clamp.

Decomposition:
- Shared package led_pkg holds:
  - state encodings ST_IDLE, ST_ON, ST_OFF, ST_GAP as localparams;
  - the zero-duration clamp function;
  - default CLK_DIV/TIME_W/NUM_W constants.
- Sub-module led_tick_gen (parameter CLK_DIV; ports i_clk, i_rst, i_en, i_clr, o_tick): the prescaler, reusable by other LED blocks.
- FSM, phase counter and remaining counter stay in the top level.

Test Plan:
- CLK_DIV=4, count=2, on=3, off=2, gap=5, repeat=0:
  - o_led pattern from accept+1: high 12, low 8, high 12, low 28 cycles.
  - o_done pulses once at cycle 60; ready returns at cycle 61.
- count=0, gap=0: o_led stays 0; o_done pulses 4 cycles after accept.
- repeat=1, count=1, on=1, off=1, gap=1: period of 12 cycles (4 high, 8 low) is stable over 5 loops; abort during ON gives o_led=0, o_busy=0, o_cmd_ready=1 the next cycle and no o_done.
- As the first scenario, with i_en=0 for 10 cycles inside the first ON: that ON lasts 22 cycles, o_led holds, and all later timing shifts by 10.
- i_cmd_valid held high with changing fields while busy: no acceptance; the fields present at the cycle ready returns are the ones executed.
- i_rst pulsed mid-GAP: next cycle o_led=0, o_busy=0, o_done=0; o_cmd_ready=1 one cycle after reset release.
